// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, baud divisor and parity helpers.
// Used by uart_tx_fifo and the future uart_rx block.
package uart_pkg;

  typedef logic [2:0] uart_state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic LINE_IDLE = 1'b1;

  // Clock cycles per bit, rounded to nearest.
  function automatic int div_calc(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  function automatic logic parity_calc(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra pointer bit for full/empty and first-word-fall-through head.
// Storage is left unreset so it can map onto iCE40 EBR or LUT RAM.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign level     = wr_ptr_r - rd_ptr_r;
  assign pop_ok_s  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push at full is still safe.
  assign push_ok_s = push && (!full || pop_ok_s);
  assign pop_data  = mem_r[rd_ptr_r[AW-1:0]];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end
  end

  // Read/write pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {(AW + 1){1'b0}};
      rd_ptr_r <= {(AW + 1){1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO write port, baud timer, frame FSM and shift register.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          wr_valid,
  input  logic [DATA_BITS-1:0]          wr_data,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int DIV = div_calc(CLK_HZ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam int BW  = $clog2(DATA_BITS + 1);
  localparam int LW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  logic [1:0]           rst_sync_r;
  logic                 rst_n_s;
  uart_state_t          state_r;
  uart_state_t          state_next_s;
  logic [CW-1:0]        cnt_r;
  logic [BW-1:0]        bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 tx_r;
  logic                 tx_s;
  logic                 busy_r;
  logic                 tick_s;
  logic                 pop_s;
  logic                 push_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic [DATA_BITS-1:0] head_s;
`ifdef UART_TX_PARITY_EN
  logic                 parity_r;
`endif

  // Reset synchroniser: assertion is immediate, release aligned to clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end
  assign rst_n_s = rst_sync_r[1];

  assign wr_ready = !fifo_full_s || pop_s;
  assign push_s   = wr_valid && wr_ready;
  assign tick_s   = (cnt_r == DIV_LAST);
  assign tx       = tx_r;
  assign busy     = busy_r;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (rst_n_s),
    .push      (push_s),
    .push_data (wr_data),
    .pop       (pop_s),
    .pop_data  (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .level     (fifo_level)
  );

  // Frame sequencing; pops the next byte on leaving IDLE or at the end of STOP.
  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s        = 1'b1;
          state_next_s = ST_START;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s) state_next_s = ST_DATA;
        else        state_next_s = ST_START;
      end
      ST_DATA: begin
        if (tick_s && (bit_cnt_r == DATA_LAST)) begin
`ifdef UART_TX_PARITY_EN
          state_next_s = ST_PARITY;
`else
          state_next_s = ST_STOP;
`endif
        end else begin
          state_next_s = ST_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick_s) state_next_s = ST_STOP;
        else        state_next_s = ST_PARITY;
      end
`endif
      ST_STOP: begin
        if (tick_s && (bit_cnt_r == STOP_LAST)) begin
          if (!fifo_empty_s) begin
            pop_s        = 1'b1;
            state_next_s = ST_START;
          end else begin
            state_next_s = ST_IDLE;
          end
        end else begin
          state_next_s = ST_STOP;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Line level for the current state; registered one cycle later.
  always_comb begin
    tx_s = LINE_IDLE;
    case (state_r)
      ST_IDLE:   tx_s = LINE_IDLE;
      ST_START:  tx_s = 1'b0;
      ST_DATA:   tx_s = shift_r[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_s = parity_r;
`endif
      ST_STOP:   tx_s = 1'b1;
      default:   tx_s = LINE_IDLE;
    endcase
  end

  // FSM state, baud timer, bit counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CW{1'b0}};
      bit_cnt_r <= {BW{1'b0}};
      tx_r      <= LINE_IDLE;
      busy_r    <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if ((state_r == ST_IDLE) || tick_s) cnt_r <= {CW{1'b0}};
      else                                cnt_r <= cnt_r + {{(CW - 1){1'b0}}, 1'b1};
      if (state_next_s != state_r) bit_cnt_r <= {BW{1'b0}};
      else if (tick_s)             bit_cnt_r <= bit_cnt_r + {{(BW - 1){1'b0}}, 1'b1};
      tx_r   <= tx_s;
      busy_r <= (state_r != ST_IDLE) || (fifo_level != LW'(0));
    end
  end

  // Payload shift register, LSB goes out first.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      shift_r <= {DATA_BITS{1'b0}};
    end else if (pop_s) begin
      shift_r <= head_s;
    end else if ((state_r == ST_DATA) && tick_s) begin
      shift_r <= shift_r >> 1;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity of the popped byte, held for the PARITY bit.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      parity_r <= 1'b0;
    end else if (pop_s) begin
      parity_r <= parity_calc(8'(head_s), PARITY_ODD[0]);
    end
  end
`endif

endmodule
